config_write_sequencer: RTL and testbench

CONFIG_WRITE_SEQUENCER -- requirements
Module: config_write_sequencer

---
 rtl/backend_cfg_pkg.sv | 76 +++++++
 rtl/cfg_req_fifo.sv | 56 +++++
 rtl/config_write_sequencer.sv | 156 +++++++++++++++
 tb/tb_config_write_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backend_cfg_pkg.sv
// ============================================================================
// Module   : backend_cfg_pkg
// Brief    : Shared register indices, half-word addresses, FSM states and
//            index-to-address helpers for the configuration write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package backend_cfg_pkg;

    localparam int NUM_CFG_REGS    = 7;
    localparam int c_NUM_HALFWORDS = 10;

    localparam logic [3:0] c_IDX_CCR0           = 4'd0;
    localparam logic [3:0] c_IDX_CCR1           = 4'd1;
    localparam logic [3:0] c_IDX_ORDER_COMPLETE = 4'd2;
    localparam logic [3:0] c_IDX_ROW_LIMIT      = 4'd3;
    localparam logic [3:0] c_IDX_COL_LIMIT      = 4'd4;
    localparam logic [3:0] c_IDX_INVERTER_SEL   = 4'd5;
    localparam logic [3:0] c_IDX_ROW_COL_SEL    = 4'd6;

    localparam logic [5:0] c_ADDR_CCR0_LO           = 6'h00;
    localparam logic [5:0] c_ADDR_CCR0_HI           = 6'h01;
    localparam logic [5:0] c_ADDR_CCR1_LO           = 6'h02;
    localparam logic [5:0] c_ADDR_CCR1_HI           = 6'h03;
    localparam logic [5:0] c_ADDR_ORDER_COMPLETE_LO = 6'h04;
    localparam logic [5:0] c_ADDR_ORDER_COMPLETE_HI = 6'h05;
    localparam logic [5:0] c_ADDR_ROW_LIMIT         = 6'h06;
    localparam logic [5:0] c_ADDR_COL_LIMIT         = 6'h07;
    localparam logic [5:0] c_ADDR_INVERTER_SEL      = 6'h08;
    localparam logic [5:0] c_ADDR_ROW_COL_SEL       = 6'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] idx);
        return idx < 4'(NUM_CFG_REGS);
    endfunction

    function automatic logic is_wide(input logic [3:0] idx);
        return idx <= c_IDX_ORDER_COMPLETE;
    endfunction

    // Low half-word address of a legal index; the high half sits at +1.
    function automatic logic [5:0] lo_addr(input logic [3:0] idx);
        case (idx)
            c_IDX_CCR0:           return c_ADDR_CCR0_LO;
            c_IDX_CCR1:           return c_ADDR_CCR1_LO;
            c_IDX_ORDER_COMPLETE: return c_ADDR_ORDER_COMPLETE_LO;
            c_IDX_ROW_LIMIT:      return c_ADDR_ROW_LIMIT;
            c_IDX_COL_LIMIT:      return c_ADDR_COL_LIMIT;
            c_IDX_INVERTER_SEL:   return c_ADDR_INVERTER_SEL;
            c_IDX_ROW_COL_SEL:    return c_ADDR_ROW_COL_SEL;
            default:              return 6'h00;
        endcase
    endfunction

    function automatic logic [3:0] lo_slot(input logic [3:0] idx);
        case (idx)
            c_IDX_CCR0:           return 4'd0;
            c_IDX_CCR1:           return 4'd2;
            c_IDX_ORDER_COMPLETE: return 4'd4;
            c_IDX_ROW_LIMIT:      return 4'd6;
            c_IDX_COL_LIMIT:      return 4'd7;
            c_IDX_INVERTER_SEL:   return 4'd8;
            c_IDX_ROW_COL_SEL:    return 4'd9;
            default:              return 4'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_req_fifo.sv
// ============================================================================
// Module   : cfg_req_fifo
// Brief    : Synchronous FIFO holding {reg_index, data} write requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/config_write_sequencer.sv
// ============================================================================
// Module   : config_write_sequencer
// Brief    : Queues host register writes and serialises them into registered
//            half-word strobes for the cycle controller.
//            Optional macro CFG_SHADOW_EN adds a readable shadow register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_write_sequencer
    import backend_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_reg,
    input  logic [31:0] req_data,
`ifdef CFG_SHADOW_EN
    input  logic [3:0]  rd_reg,
    output logic [31:0] rd_data,
`endif
    output logic        write_config_n,
    output logic [5:0]  config_address,
    output logic [15:0] config_data,
    output logic        busy,
    output logic        err_illegal
);

    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [35:0] w_head;
    logic [3:0]  w_head_reg;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_wide,     w_wide_nxt;
    logic [5:0]  r_hi_addr,  w_hi_addr_nxt;
    logic [15:0] r_hi_data,  w_hi_data_nxt;
    logic        r_wcn,      w_wcn_nxt;
    logic [5:0]  r_addr,     w_addr_nxt;
    logic [15:0] r_data,     w_data_nxt;
    logic        r_err,      w_err_nxt;

    assign w_push     = req_valid && !w_full;
    assign w_head_reg = w_head[35:32];

    cfg_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data ({req_reg, req_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_state_nxt   = IDLE;
        w_pop         = 1'b0;
        w_wcn_nxt     = 1'b1;
        w_addr_nxt    = '0;
        w_data_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_wide_nxt    = 1'b0;
        w_hi_addr_nxt = r_hi_addr;
        w_hi_data_nxt = r_hi_data;

        if (r_state == LO && r_wide) begin
            w_state_nxt = HI;
            w_wcn_nxt   = 1'b0;
            w_addr_nxt  = r_hi_addr;
            w_data_nxt  = r_hi_data;
        end else if (!w_empty) begin
            // Every other state can pop, so a fed queue gives one half-word per cycle.
            w_pop       = 1'b1;
            w_state_nxt = LO;
            if (is_legal(w_head_reg)) begin
                w_wcn_nxt     = 1'b0;
                w_addr_nxt    = lo_addr(w_head_reg);
                w_data_nxt    = w_head[15:0];
                w_wide_nxt    = is_wide(w_head_reg);
                w_hi_addr_nxt = lo_addr(w_head_reg) + 6'd1;
                w_hi_data_nxt = w_head[31:16];
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wide    <= 1'b0;
            r_hi_addr <= '0;
            r_hi_data <= '0;
            r_wcn     <= 1'b1;
            r_addr    <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wide    <= w_wide_nxt;
            r_hi_addr <= w_hi_addr_nxt;
            r_hi_data <= w_hi_data_nxt;
            r_wcn     <= w_wcn_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign req_ready      = !w_full;
    assign busy           = !w_empty || (r_state != IDLE);
    assign write_config_n = r_wcn;
    assign config_address = r_addr;
    assign config_data    = r_data;
    assign err_illegal    = r_err;

`ifdef CFG_SHADOW_EN
    logic [15:0] r_shadow [c_NUM_HALFWORDS];
    logic [3:0]  w_rd_slot;

    // Commit the half-word currently on the bus at the end of its strobe cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_HALFWORDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (!r_wcn && (r_addr <= c_ADDR_ROW_COL_SEL)) begin
            r_shadow[r_addr[3:0]] <= r_data;
        end
    end

    always_comb begin
        w_rd_slot = lo_slot(rd_reg);
        rd_data   = '0;
        if (is_wide(rd_reg)) begin
            rd_data = {r_shadow[w_rd_slot + 4'd1], r_shadow[w_rd_slot]};
        end else if (is_legal(rd_reg)) begin
            rd_data = {16'h0000, r_shadow[w_rd_slot]};
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_config_write_sequencer.sv
// ============================================================================
// Module   : tb_config_write_sequencer
// Brief    : Directed self-checking bench for config_write_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_write_sequencer;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_reg;
    logic [31:0] req_data;
    logic        write_config_n;
    logic [5:0]  config_address;
    logic [15:0] config_data;
    logic        busy;
    logic        err_illegal;
`ifdef CFG_SHADOW_EN
    logic [3:0]  rd_reg;
    logic [31:0] rd_data;
`endif

    int checks;
    int errors;
    int cyc;
    int err_cnt;

    typedef struct {
        int          cyc;
        logic [5:0]  a;
        logic [15:0] d;
    } bus_t;
    bus_t bus_q[$];

    config_write_sequencer #(.FIFO_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg        (req_reg),
        .req_data       (req_data),
`ifdef CFG_SHADOW_EN
        .rd_reg         (rd_reg),
        .rd_data        (rd_data),
`endif
        .write_config_n (write_config_n),
        .config_address (config_address),
        .config_data    (config_data),
        .busy           (busy),
        .err_illegal    (err_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial err_cnt = 0;
    always @(negedge clock) begin
        bus_t e;
        if (write_config_n === 1'b0) begin
            e.cyc = cyc;
            e.a   = config_address;
            e.d   = config_data;
            bus_q.push_back(e);
        end
        if (err_illegal === 1'b1) err_cnt = err_cnt + 1;
    end

    // Returns just after the accepting edge; stalls = cycles spent with ready low.
    task automatic push_req(input logic [3:0] r, input logic [31:0] d, output int stalls);
        bit done;
        stalls = 0;
        done   = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_reg   = r;
        req_data  = d;
        for (int t = 0; t < 200 && !done; t++) begin
            if (req_ready === 1'b1) done = 1'b1;
            else stalls++;
            @(posedge clock);
            if (!done) @(negedge clock);
        end
        #1;
        req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: req_ready stayed %b, required 1 within 200 cycles", req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (write_config_n !== 1'b1) begin errors++; $display("FAIL rst_wcn: got %b expected 1", write_config_n); end
        checks++; if (config_address !== 6'h00) begin errors++; $display("FAIL rst_addr: got %h expected 00", config_address); end
        checks++; if (config_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h expected 0000", config_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_illegal); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_ccr0_write();
        int st;
        push_req(4'd0, 32'h1234_5678, st);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ccr0_busy_queued: got %b expected 1", busy); end
        checks++; if (write_config_n !== 1'b1) begin errors++; $display("FAIL ccr0_no_early_strobe: got %b expected 1", write_config_n); end
        @(posedge clock); #1;
        checks++; if ({write_config_n, config_address, config_data} !== {1'b0, 6'h00, 16'h5678})
            begin errors++; $display("FAIL ccr0_lo: got wcn=%b a=%h d=%h expected 0/00/5678", write_config_n, config_address, config_data); end
        @(posedge clock); #1;
        checks++; if ({write_config_n, config_address, config_data} !== {1'b0, 6'h01, 16'h1234})
            begin errors++; $display("FAIL ccr0_hi: got wcn=%b a=%h d=%h expected 0/01/1234", write_config_n, config_address, config_data); end
        @(posedge clock); #1;
        checks++; if ({write_config_n, config_address, config_data} !== {1'b1, 6'h00, 16'h0000})
            begin errors++; $display("FAIL ccr0_idle: got wcn=%b a=%h d=%h expected 1/00/0000", write_config_n, config_address, config_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ccr0_busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int st;
        int b;
        logic [5:0]  exp_a [3];
        logic [15:0] exp_d [3];
        exp_a = '{6'h06, 6'h07, 6'h08};
        exp_d = '{16'h0005, 16'h0003, 16'hA5A5};
        b = bus_q.size();
        push_req(4'd3, 32'h0000_0005, st);
        push_req(4'd4, 32'h0000_0003, st);
        push_req(4'd5, 32'h0000_A5A5, st);
        repeat (5) @(posedge clock);
        #1;
        checks++; if (bus_q.size() - b !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus_q.size() - b); end
        if (bus_q.size() - b == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (bus_q[b+i].a !== exp_a[i] || bus_q[b+i].d !== exp_d[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h/%h expected %h/%h", i, bus_q[b+i].a, bus_q[b+i].d, exp_a[i], exp_d[i]);
                end
            end
            checks++;
            if (bus_q[b+1].cyc != bus_q[b].cyc + 1 || bus_q[b+2].cyc != bus_q[b].cyc + 2) begin
                errors++;
                $display("FAIL b2b_gapless: got cycles %0d,%0d,%0d expected consecutive", bus_q[b].cyc, bus_q[b+1].cyc, bus_q[b+2].cyc);
            end
        end
    endtask

    task automatic test_fifo_full();
        int st;
        int b;
        int first_stall;
        logic [5:0]  ea;
        logic [15:0] ed;
        b = bus_q.size();
        first_stall = -1;
        for (int i = 0; i < 10; i++) begin
            push_req(4'(i % 3), {16'(16'hA000 + i), 16'(16'h5000 + i)}, st);
            if (st > 0 && first_stall < 0) first_stall = i;
        end
        repeat (30) @(posedge clock);
        #1;
        checks++; if (first_stall != 7) begin errors++; $display("FAIL full_first_stall: got request %0d expected 7", first_stall); end
        checks++; if (bus_q.size() - b !== 20) begin errors++; $display("FAIL full_count: got %0d expected 20", bus_q.size() - b); end
        if (bus_q.size() - b == 20) begin
            for (int i = 0; i < 20; i++) begin
                ea = 6'((i / 2) % 3 * 2 + (i % 2));
                ed = (i % 2 == 0) ? 16'(16'h5000 + i / 2) : 16'(16'hA000 + i / 2);
                checks++;
                if (bus_q[b+i].a !== ea || bus_q[b+i].d !== ed) begin
                    errors++;
                    $display("FAIL full_order%0d: got %h/%h expected %h/%h", i, bus_q[b+i].a, bus_q[b+i].d, ea, ed);
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_illegal();
        int st;
        int b;
        int e0;
        b  = bus_q.size();
        e0 = err_cnt;
        push_req(4'd9, 32'hFFFF_FFFF, st);
        push_req(4'd1, 32'hFFFF_0001, st);
        repeat (6) @(posedge clock);
        #1;
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL illegal_pulses: got %0d expected 1", err_cnt - e0); end
        checks++; if (bus_q.size() - b !== 2) begin errors++; $display("FAIL illegal_count: got %0d expected 2", bus_q.size() - b); end
        if (bus_q.size() - b == 2) begin
            checks++; if (bus_q[b].a !== 6'h02 || bus_q[b].d !== 16'h0001)
                begin errors++; $display("FAIL illegal_next_lo: got %h/%h expected 02/0001", bus_q[b].a, bus_q[b].d); end
            checks++; if (bus_q[b+1].a !== 6'h03 || bus_q[b+1].d !== 16'hFFFF)
                begin errors++; $display("FAIL illegal_next_hi: got %h/%h expected 03/FFFF", bus_q[b+1].a, bus_q[b+1].d); end
        end
    endtask

    task automatic test_reset_mid();
        int st;
        int b;
        push_req(4'd1, 32'hCAFE_0BAD, st);
        @(posedge clock); #1;
        checks++; if ({write_config_n, config_address, config_data} !== {1'b0, 6'h02, 16'h0BAD})
            begin errors++; $display("FAIL mid_lo: got wcn=%b a=%h d=%h expected 0/02/0BAD", write_config_n, config_address, config_data); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({write_config_n, config_address, config_data} !== {1'b1, 6'h00, 16'h0000})
            begin errors++; $display("FAIL mid_async: got wcn=%b a=%h d=%h expected 1/00/0000", write_config_n, config_address, config_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        b = bus_q.size();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
        repeat (4) @(posedge clock);
        #1;
        checks++; if (bus_q.size() != b) begin errors++; $display("FAIL mid_no_hi: got %0d extra strobes expected 0", bus_q.size() - b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: busy got %b expected 0", busy); end
    endtask

`ifdef CFG_SHADOW_EN
    task automatic test_shadow();
        int st;
        rd_reg = 4'd2;
        #1;
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL shadow_reset: got %h expected 00000000", rd_data); end
        push_req(4'd2, 32'hDEAD_BEEF, st);
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++; if (rd_data !== 32'h0000_BEEF) begin errors++; $display("FAIL shadow_lo: got %h expected 0000BEEF", rd_data); end
        @(posedge clock); #1;
        checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL shadow_hi: got %h expected DEADBEEF", rd_data); end
        rd_reg = 4'd9;
        #1;
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL shadow_illegal: got %h expected 00000000", rd_data); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_reg   = '0;
        req_data  = '0;
`ifdef CFG_SHADOW_EN
        rd_reg    = '0;
`endif
        test_reset();
        test_ccr0_write();
        test_back_to_back();
        test_fifo_full();
        test_illegal();
        test_reset_mid();
`ifdef CFG_SHADOW_EN
        test_shadow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
